// File: rtl/ascii_digit_accumulator_if.sv
// Byte-entry handshake and result bus between the UART decoder side and the
// decimal digit accumulator.
interface ascii_digit_accumulator_if #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic               enable;
  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_ready;
  logic [VALUE_W-1:0] value;
  logic               value_valid;
  logic [CNT_W-1:0]   digit_count;
  logic               err;
  logic               quit;
  logic               busy;

  modport master (
    output enable, in_byte, in_valid,
    input  in_ready, value, value_valid, digit_count, err, quit, busy
  );

  modport slave (
    input  enable, in_byte, in_valid,
    output in_ready, value, value_valid, digit_count, err, quit, busy
  );
endinterface

// File: rtl/ascii_digit_accumulator.sv
// Buffers ASCII decimal digits with backspace/quit editing, then converts the
// entry to binary one digit per cycle on Enter.
module ascii_digit_accumulator #(
   parameter int MAX_DIGITS = 4,
   parameter int MIN_DIGITS = 1,
   parameter int VALUE_W    = 14
) (
   input logic                     clk,
   input logic                     rst_n,
   ascii_digit_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_DIGITS);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [7:0] CH_ENTER = 8'h0D;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_QUIT  = 8'h71;

   typedef enum logic [1:0] {IDLE, ENTRY, CONVERT} state_t;

   state_t                     state, state_nxt;
   logic [MAX_DIGITS-1:0][3:0] digits;
   logic [CNT_W-1:0]           count, idx;
   logic [VALUE_W-1:0]         acc, acc_next, value_r;
   logic                       vv_r, err_r, quit_r;

   logic       is_digit, accept;
   logic [3:0] cur_digit;
   logic       do_clear, do_append, do_pop, do_start, do_step, do_done;
   logic       err_nxt, quit_nxt;

   assign is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
   // During conversion only the quit byte may be taken, so it can abort.
   assign bus.in_ready = bus.enable && ((state != CONVERT) || (bus.in_byte == CH_QUIT));
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      cur_digit = 4'd0;
      for (int i = 0; i < MAX_DIGITS; i++)
         if (CNT_W'(i) == idx) cur_digit = digits[i];
   end

   assign acc_next = (acc << 3) + (acc << 1) + VALUE_W'(cur_digit);

   always_comb begin
      state_nxt = state;
      do_clear  = 1'b0;
      do_append = 1'b0;
      do_pop    = 1'b0;
      do_start  = 1'b0;
      do_step   = 1'b0;
      do_done   = 1'b0;
      err_nxt   = 1'b0;
      quit_nxt  = 1'b0;
      if (state != IDLE && !bus.enable) begin
         state_nxt = IDLE;
         do_clear  = 1'b1;
      end else if (accept && bus.in_byte == CH_QUIT) begin
         state_nxt = IDLE;
         do_clear  = 1'b1;
         quit_nxt  = 1'b1;
      end else begin
         case (state)
            IDLE: if (accept && is_digit) begin
               do_append = 1'b1;
               state_nxt = ENTRY;
            end
            ENTRY: if (accept) begin
               if (is_digit && count < MAX_CNT) begin
                  do_append = 1'b1;
               end else if (bus.in_byte == CH_BS) begin
                  do_pop = 1'b1;
                  if (count == ONE) state_nxt = IDLE;
               end else if (bus.in_byte == CH_ENTER && count >= MIN_CNT) begin
                  do_start  = 1'b1;
                  state_nxt = CONVERT;
               end else begin
                  // overflow digit, short Enter or an unknown byte
                  err_nxt   = 1'b1;
                  do_clear  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            CONVERT: if (idx == count) begin
               do_done   = 1'b1;
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end else begin
               do_step = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits  <= '0;
         count   <= '0;
         idx     <= '0;
         acc     <= '0;
         value_r <= '0;
         vv_r    <= 1'b0;
         err_r   <= 1'b0;
         quit_r  <= 1'b0;
      end else begin
         vv_r   <= do_done;
         err_r  <= err_nxt;
         quit_r <= quit_nxt;
         if (quit_nxt)     value_r <= '0;
         else if (do_done) value_r <= acc;
         if (do_clear) begin
            digits <= '0;
            count  <= '0;
            idx    <= '0;
            acc    <= '0;
         end else if (do_append) begin
            for (int i = 0; i < MAX_DIGITS; i++)
               if (CNT_W'(i) == count) digits[i] <= bus.in_byte[3:0];
            count <= count + ONE;
         end else if (do_pop) begin
            for (int i = 0; i < MAX_DIGITS; i++)
               if (CNT_W'(i) == count - ONE) digits[i] <= 4'd0;
            count <= count - ONE;
         end else if (do_start) begin
            acc <= '0;
            idx <= '0;
         end else if (do_step) begin
            acc <= acc_next;
            idx <= idx + ONE;
         end
      end
   end

   assign bus.value       = value_r;
   assign bus.value_valid = vv_r;
   assign bus.digit_count = count;
   assign bus.err         = err_r;
   assign bus.quit        = quit_r;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_ascii_digit_accumulator.sv
// Drives two accumulators (MIN_DIGITS 1 and 4) with identical byte streams and
// compares every output each cycle against a decimal-entry reference model.
module tb_ascii_digit_accumulator;
   localparam int MAXD = 4;
   localparam int VW   = 14;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ascii_digit_accumulator_if #(.MAX_DIGITS(MAXD), .VALUE_W(VW)) bus0();
   ascii_digit_accumulator_if #(.MAX_DIGITS(MAXD), .VALUE_W(VW)) bus1();

   ascii_digit_accumulator #(.MAX_DIGITS(MAXD), .MIN_DIGITS(1), .VALUE_W(VW))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   ascii_digit_accumulator #(.MAX_DIGITS(MAXD), .MIN_DIGITS(4), .VALUE_W(VW))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: mode 0 idle, 1 entry, 2 converting
   int min_d [2] = '{1, 4};
   int m_mode[2], m_n[2], m_res[2], m_timer[2];
   int m_dig [2][MAXD];
   int e_value[2];
   bit e_vv[2], e_err[2], e_quit[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_n[k] = 0; m_res[k] = 0; m_timer[k] = 0;
         e_value[k] = 0; e_vv[k] = 0; e_err[k] = 0; e_quit[k] = 0;
      end
   endtask

   function automatic bit model_ready(int k, bit en, logic [7:0] b);
      return en && (m_mode[k] != 2 || b == 8'h71);
   endfunction

   function automatic int decimal_value(int k);
      int r = 0;
      for (int i = 0; i < m_n[k]; i++) r += m_dig[k][i] * (10 ** (m_n[k] - 1 - i));
      return r;
   endfunction

   task automatic model_step(int k, bit en, logic [7:0] b, bit v);
      bit is_dig = (b >= 8'h30 && b <= 8'h39);
      e_vv[k] = 0; e_err[k] = 0; e_quit[k] = 0;
      if (m_mode[k] != 0 && !en) begin
         m_mode[k] = 0; m_n[k] = 0;
      end else if (v && model_ready(k, en, b)) begin
         if (b == 8'h71) begin
            m_mode[k] = 0; m_n[k] = 0; e_quit[k] = 1; e_value[k] = 0;
         end else if (m_mode[k] == 0) begin
            if (is_dig) begin m_dig[k][0] = int'(b) - 48; m_n[k] = 1; m_mode[k] = 1; end
         end else if (is_dig && m_n[k] < MAXD) begin
            m_dig[k][m_n[k]] = int'(b) - 48; m_n[k]++;
         end else if (b == 8'h08) begin
            m_n[k]--;
            if (m_n[k] == 0) m_mode[k] = 0;
         end else if (b == 8'h0D && m_n[k] >= min_d[k]) begin
            m_res[k] = decimal_value(k); m_timer[k] = m_n[k] + 1; m_mode[k] = 2;
         end else begin
            e_err[k] = 1; m_mode[k] = 0; m_n[k] = 0;
         end
      end else if (m_mode[k] == 2) begin
         m_timer[k]--;
         if (m_timer[k] == 0) begin
            e_value[k] = m_res[k]; e_vv[k] = 1; m_mode[k] = 0; m_n[k] = 0;
         end
      end
   endtask

   task automatic check_one(input int k, input logic [31:0] val, input logic vv,
                            input logic [31:0] cnt, input logic er, input logic qu,
                            input logic bz);
      string p = $sformatf("d%0d.", k);
      chk({p, "value"}, val, e_value[k]);
      chk({p, "value_valid"}, 32'(vv), 32'(e_vv[k]));
      chk({p, "digit_count"}, cnt, m_n[k]);
      chk({p, "err"}, 32'(er), 32'(e_err[k]));
      chk({p, "quit"}, 32'(qu), 32'(e_quit[k]));
      chk({p, "busy"}, 32'(bz), 32'(m_mode[k] != 0));
   endtask

   task automatic check_outputs();
      check_one(0, 32'(bus0.value), bus0.value_valid, 32'(bus0.digit_count),
                bus0.err, bus0.quit, bus0.busy);
      check_one(1, 32'(bus1.value), bus1.value_valid, 32'(bus1.digit_count),
                bus1.err, bus1.quit, bus1.busy);
   endtask

   task automatic drive(input bit en, input logic [7:0] b, input bit v);
      bus0.enable = en; bus0.in_byte = b; bus0.in_valid = v;
      bus1.enable = en; bus1.in_byte = b; bus1.in_valid = v;
   endtask

   // one clock: check state left by the previous edge, then apply inputs
   task automatic cyc(input bit en, input logic [7:0] b, input bit v);
      @(negedge clk);
      check_outputs();
      drive(en, b, v);
      #1;
      chk("d0.in_ready", 32'(bus0.in_ready), 32'(model_ready(0, en, b)));
      chk("d1.in_ready", 32'(bus1.in_ready), 32'(model_ready(1, en, b)));
      model_step(0, en, b, v);
      model_step(1, en, b, v);
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b1, 8'h00, 1'b0);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      check_outputs();
      drive(1'b1, 8'h00, 1'b0);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] junk [8] = '{8'h41, 8'h20, 8'h2F, 8'h3A, 8'h00, 8'hFF, 8'h51, 8'h0A};
      int r = $urandom_range(0, 99);
      if (r < 50) return 8'h30 + 8'($urandom_range(0, 9));
      if (r < 63) return 8'h0D;
      if (r < 73) return 8'h08;
      if (r < 77) return 8'h71;
      return junk[$urandom_range(0, 7)];
   endfunction

   initial begin
      model_reset();
      drive(1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      send_str("1234"); send(8'h0D); idle(7);
      send_str("99995"); idle(2);
      send_str("47"); send(8'h08); send_str("2"); send(8'h0D); idle(5);
      send_str("5"); send(8'h08); idle(2);
      send_str("12q"); idle(2);
      send_str("123"); send(8'h0D); idle(1); send_str("7"); send_str("q"); idle(5);
      send_str("3A"); idle(2);
      send_str("12"); send(8'h0D); idle(5);
      send_str("12"); cyc(1'b0, 8'h00, 1'b0); idle(2);
      send_str("987"); send(8'h0D); idle(1); cyc(1'b0, 8'h00, 1'b0); idle(5);
      send_str("5678"); send(8'h0D); idle(2);
      reset_mid();
      send_str("0"); send(8'h0D); idle(4);

      for (int i = 0; i < 2000; i++)
         cyc($urandom_range(0, 99) < 96, rand_byte(), $urandom_range(0, 99) < 70);
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
